// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write-side bundle shared by the RF/ALU result sources and the arbiter.
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ALU_OUT_WIDTH = 2*DATA_WIDTH
);
   logic                     RF_REQ;
   logic [DATA_WIDTH-1:0]    RF_DATA;
   logic                     RF_ACK;
   logic                     ALU_REQ;
   logic [ALU_OUT_WIDTH-1:0] ALU_DATA;
   logic                     ALU_ACK;
   logic                     FIFO_FULL;
   logic [DATA_WIDTH-1:0]    WR_DATA;
   logic                     WR_INC;
   logic                     BUSY;

   modport slave (
      input  RF_REQ, RF_DATA, ALU_REQ, ALU_DATA, FIFO_FULL,
      output RF_ACK, ALU_ACK, WR_DATA, WR_INC, BUSY
   );

   modport master (
      output RF_REQ, RF_DATA, ALU_REQ, ALU_DATA, FIFO_FULL,
      input  RF_ACK, ALU_ACK, WR_DATA, WR_INC, BUSY
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port between the RF byte path and the
// two-byte ALU result path; ALU bursts are atomic and FIFO_FULL stalls the send states.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH    = 8,
   parameter int ALU_OUT_WIDTH = 2*DATA_WIDTH
) (
   input  logic              CLK,
   input  logic              RST,
   fifo_wr_arbiter_if.slave  arb
);
   typedef enum logic [1:0] {IDLE, SEND_RF, SEND_ALU_LO, SEND_ALU_HI} state_e;

   state_e                state_q, state_d;
   logic                  ptr_alu_q, ptr_alu_d;   // 0: RF has priority, 1: ALU has priority
   logic [DATA_WIDTH-1:0] hi_q, hi_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  rf_ack, alu_ack, wr_inc;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         ptr_alu_q <= 1'b0;
         hi_q      <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_alu_q <= ptr_alu_d;
         hi_q      <= hi_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_alu_d = ptr_alu_q;
      hi_d      = hi_q;
      wr_data_d = wr_data_q;
      rf_ack    = 1'b0;
      alu_ack   = 1'b0;
      wr_inc    = 1'b0;
      case (state_q)
         IDLE: begin
            // ACKs are combinational, so keep them quiet while reset is held
            if (RST) begin
               if (arb.RF_REQ && (!arb.ALU_REQ || !ptr_alu_q)) begin
                  rf_ack    = 1'b1;
                  state_d   = SEND_RF;
                  ptr_alu_d = 1'b1;
                  wr_data_d = arb.RF_DATA;
               end else if (arb.ALU_REQ) begin
                  alu_ack   = 1'b1;
                  state_d   = SEND_ALU_LO;
                  ptr_alu_d = 1'b0;
                  wr_data_d = arb.ALU_DATA[DATA_WIDTH-1:0];
                  hi_d      = arb.ALU_DATA[ALU_OUT_WIDTH-1:DATA_WIDTH];
               end
            end
         end
         SEND_RF: begin
            wr_inc = !arb.FIFO_FULL;
            if (wr_inc) state_d = IDLE;
         end
         SEND_ALU_LO: begin
            wr_inc = !arb.FIFO_FULL;
            if (wr_inc) begin
               state_d   = SEND_ALU_HI;
               wr_data_d = hi_q;
            end
         end
         SEND_ALU_HI: begin
            wr_inc = !arb.FIFO_FULL;
            if (wr_inc) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign arb.RF_ACK  = rf_ack;
   assign arb.ALU_ACK = alu_ack;
   assign arb.WR_INC  = wr_inc;
   assign arb.WR_DATA = wr_data_q;
   assign arb.BUSY    = (state_q != IDLE);
endmodule
